// File: rtl/mem_access.sv
// Data-memory access unit for the MEM stage: it aligns and issues load/store requests,
// stalls the pipeline until the memory acknowledges or times out, and extracts load data.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [1:0]      off_reg;
  logic [1:0]      size_reg;
  logic            sign_reg;
  logic            load_reg;

  logic            access, aligned, start, timeout_hit;
  logic [3:0]      be_calc;
  logic [31:0]     wdata_calc;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_ext;

  assign access      = mem_read | mem_write;
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

  always_comb begin
    aligned    = 1'b1;
    be_calc    = 4'b1111;
    wdata_calc = write_data;
    case (size)
      2'b00: begin
        be_calc    = 4'b0001 << address[1:0];
        wdata_calc = {4{write_data[7:0]}};
      end
      2'b01: begin
        aligned    = ~address[0];
        be_calc    = address[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{write_data[15:0]}};
      end
      default: aligned = (address[1:0] == 2'b00);
    endcase
  end

  // Extraction uses the offset/size/sign captured at issue, not the live inputs.
  always_comb begin
    case (off_reg)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_reg)
      2'b00:   load_ext = {{24{sign_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sign_reg & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    start      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (access) begin
          if (aligned) begin
            stall      = 1'b1;
            start      = 1'b1;
            state_next = ST_WAIT;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_next = ST_DONE;
        end else if (timeout_hit) begin
          bus_err    = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Pulses must read zero while reset is held, whatever the inputs are doing.
    if (!rst_n) begin
      stall      = 1'b0;
      misaligned = 1'b0;
      bus_err    = 1'b0;
      start      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      read_data <= '0;
      cnt_reg   <= '0;
      off_reg   <= '0;
      size_reg  <= '0;
      sign_reg  <= 1'b0;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= mem_write;
        mem_addr  <= {address[DATA_W-1:2], 2'b00};
        mem_be    <= be_calc;
        mem_wdata <= wdata_calc;
        cnt_reg   <= '0;
        off_reg   <= address[1:0];
        size_reg  <= size;
        sign_reg  <= sign_ext;
        load_reg  <= ~mem_write;
      end
      if (state_reg == ST_WAIT) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          if (load_reg) read_data <= load_ext;
        end else if (timeout_hit) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment, timeout and reset abort.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [31:0] address, write_data, mem_rdata;
  logic        mem_req, mem_we, stall, misaligned, bus_err;
  logic [31:0] mem_addr, mem_wdata, read_data;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  mem_access #(.TIMEOUT(16), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .sign_ext(sign_ext),
    .address(address), .write_data(write_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .read_data(read_data), .stall(stall), .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sg;
    address = a; write_data = wd;
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; size = 0; sign_ext = 0;
    address = 0; write_data = 0;
  endtask

  // One load acknowledged in its first WAIT cycle; checks enables and extracted data.
  task automatic quick_load(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] rd,
                            input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue(1, 0, sz, sg, a, 32'h0);
    tick();
    chk({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
    mem_ack = 1; mem_rdata = rd;
    tick();
    mem_ack = 0;
    chk({tag, "_data"}, read_data, exp_data);
    $display("load %s addr=%h be=%b data=%h", tag, a, exp_be, read_data);
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 0; mem_ack = 0; mem_rdata = 0;
    idle_inputs();
    #2;
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    #10 rst_n = 1;
    tick();

    // Word load at 0x100, ack in the second WAIT cycle.
    issue(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0);
    chk("w_stall_idle", {31'h0, stall}, 32'h1);
    tick();
    chk("w_req", {31'h0, mem_req}, 32'h1);
    chk("w_we", {31'h0, mem_we}, 32'h0);
    chk("w_addr", mem_addr, 32'h0000_0100);
    chk("w_be", {28'h0, mem_be}, 32'hF);
    chk("w_stall_w1", {31'h0, stall}, 32'h1);
    tick();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("w_stall_w2", {31'h0, stall}, 32'h1);
    tick();
    mem_ack = 0;
    chk("w_done_req", {31'h0, mem_req}, 32'h0);
    chk("w_done_stall", {31'h0, stall}, 32'h0);
    chk("w_data", read_data, 32'hDEAD_BEEF);
    $display("load word addr=00000100 data=%h", read_data);
    idle_inputs();
    tick();
    chk("w_idle_stall", {31'h0, stall}, 32'h0);

    quick_load("sb", 2'b00, 1, 32'h0000_0103, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80);
    quick_load("ub", 2'b00, 0, 32'h0000_0103, 32'h8011_2233, 4'b1000, 32'h0000_0080);
    quick_load("sh", 2'b01, 1, 32'h0000_0102, 32'h8011_2233, 4'b1100, 32'hFFFF_8011);
    quick_load("ub1", 2'b00, 0, 32'h0000_0001, 32'h8011_2233, 4'b0010, 32'h0000_0022);

    // Half store at 0x206.
    issue(0, 1, 2'b01, 0, 32'h0000_0206, 32'hABCD_1234);
    tick();
    chk("hs_we", {31'h0, mem_we}, 32'h1);
    chk("hs_addr", mem_addr, 32'h0000_0204);
    chk("hs_be", {28'h0, mem_be}, 32'hC);
    chk("hs_wdata", mem_wdata, 32'h1234_1234);
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 0;
    chk("hs_hold", read_data, 32'h0000_0022);
    $display("store half addr=00000206 wdata=%h", mem_wdata);
    idle_inputs();
    tick();

    // Byte store, both read and write requested: treated as a write.
    issue(1, 1, 2'b00, 0, 32'h0000_0301, 32'h0000_00A5);
    tick();
    chk("bs_we", {31'h0, mem_we}, 32'h1);
    chk("bs_be", {28'h0, mem_be}, 32'h2);
    chk("bs_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("bs_hold", read_data, 32'h0000_0022);
    $display("store byte addr=00000301 wdata=%h", mem_wdata);
    idle_inputs();
    tick();

    // Misaligned word load.
    issue(1, 0, 2'b10, 0, 32'h0000_0102, 32'h0);
    chk("mis_pulse", {31'h0, misaligned}, 32'h1);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("mis_req", {31'h0, mem_req}, 32'h0);
    idle_inputs();
    #1;
    chk("mis_clear", {31'h0, misaligned}, 32'h0);
    chk("mis_hold", read_data, 32'h0000_0022);
    $display("misaligned word addr=00000102 req=%0b", mem_req);
    tick();

    // Timeout: 16 WAIT cycles, BusErr on the 16th.
    issue(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    tick();
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("to_noerr%0d", i), {30'h0, bus_err, mem_req}, 32'h1);
      tick();
    end
    chk("to_err", {31'h0, bus_err}, 32'h1);
    tick();
    chk("to_done", {29'h0, bus_err, mem_req, stall}, 32'h0);
    chk("to_hold", read_data, 32'h0000_0022);
    $display("timeout load addr=00000010 bus_err seen");
    idle_inputs();
    tick();

    // Ack coincides with the 16th WAIT cycle: ack wins.
    issue(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    tick();
    for (int i = 1; i < 16; i++) tick();
    mem_ack = 1; mem_rdata = 32'h1357_2468;
    #1;
    chk("race_noerr", {31'h0, bus_err}, 32'h0);
    tick();
    mem_ack = 0;
    chk("race_data", read_data, 32'h1357_2468);
    $display("late ack load data=%h", read_data);
    idle_inputs();
    tick();

    // Reset in the middle of WAIT, then a stale ack.
    issue(1, 0, 2'b10, 0, 32'h0000_0400, 32'h0);
    tick();
    chk("rw_req", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 0;
    #1;
    chk("rw_zero", {27'h0, mem_req, mem_we, stall, misaligned, bus_err}, 32'h0);
    chk("rw_addr", mem_addr, 32'h0);
    chk("rw_data", read_data, 32'h0);
    idle_inputs();
    tick();
    rst_n = 1;
    tick();
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 0;
    chk("stale_req", {30'h0, mem_req, stall}, 32'h0);
    chk("stale_data", read_data, 32'h0);
    $display("reset abort req=%0b data=%h", mem_req, read_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
